// File: rtl/limbus_mtimer_pkg.sv
`default_nettype none
// ============================================================================
// limbus_mtimer_pkg : register map and field indices for limbus_mtimer
// Revision: 1.0
// ============================================================================
package limbus_mtimer_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_SNAP   = 3'd3;
    localparam logic [2:0] REG_CMP    = 3'd4;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    localparam int CTRL_RUN   = 4;

    localparam int STATUS_TO  = 0;

    function automatic int addr_width(input int num_ch);
        return $clog2(num_ch) + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/limbus_mtimer_ch.sv
`default_nettype none
// ============================================================================
// limbus_mtimer_ch : one down-counter channel with snapshot, sticky timeout
// and optional compare output (LIMBUS_MTIMER_PWM_EN).   Revision: 1.0
// ============================================================================
module limbus_mtimer_ch
    import limbus_mtimer_pkg::*;
#(
    parameter int CNT_W                 = 32,
    parameter logic [CNT_W-1:0] DEF_VAL = '0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_i,
    input  logic        wr_i,
    input  logic [2:0]  reg_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
`ifdef LIMBUS_MTIMER_PWM_EN
    output logic        pwm_o,
`endif
    output logic        irq_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic             run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic             w_timeout;
`ifdef LIMBUS_MTIMER_PWM_EN
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             pwm_q;
`endif

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        snap_d    = snap_q;
        run_d     = run_q;
        to_d      = to_q;
        ito_d     = ito_q;
        cont_d    = cont_q;
`ifdef LIMBUS_MTIMER_PWM_EN
        cmp_d     = cmp_q;
`endif
        w_timeout = run_q & tick_i & (cnt_q == '0);

        if (run_q && tick_i) begin
            if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
            else if (cont_q)  cnt_d = period_q;
            else              run_d = 1'b0;
        end

        // Bus writes take priority over the counting step in the same cycle
        if (wr_i) begin
            case (reg_i)
                REG_CTRL: begin
                    ito_d  = wdata_i[CTRL_ITO];
                    cont_d = wdata_i[CTRL_CONT];
                    if (wdata_i[CTRL_START]) begin
                        cnt_d = period_q;
                        run_d = 1'b1;
                    end else if (wdata_i[CTRL_STOP]) begin
                        run_d = 1'b0;
                    end
                end
                REG_STATUS: if (wdata_i[STATUS_TO]) to_d = 1'b0;
                REG_PERIOD: begin
                    period_d = wdata_i[CNT_W-1:0];
                    cnt_d    = wdata_i[CNT_W-1:0];
                    run_d    = 1'b0;
                end
                REG_SNAP: snap_d = cnt_q;
`ifdef LIMBUS_MTIMER_PWM_EN
                REG_CMP:  cmp_d = wdata_i[CNT_W-1:0];
`endif
                default: ;
            endcase
        end

        // A timeout never gets lost to a simultaneous clear
        if (w_timeout) to_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= DEF_VAL;
            period_q <= DEF_VAL;
            snap_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            ito_q    <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            run_q    <= run_d;
            to_q     <= to_d;
            ito_q    <= ito_d;
            cont_q   <= cont_d;
        end
    end

`ifdef LIMBUS_MTIMER_PWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            pwm_q <= run_q & (cnt_q < cmp_q);
        end
    end
    assign pwm_o = pwm_q;
`endif

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_CTRL: begin
                rdata_o[CTRL_ITO]  = ito_q;
                rdata_o[CTRL_CONT] = cont_q;
                rdata_o[CTRL_RUN]  = run_q;
            end
            REG_STATUS: rdata_o[STATUS_TO]   = to_q;
            REG_PERIOD: rdata_o[CNT_W-1:0]   = period_q;
            REG_SNAP:   rdata_o[CNT_W-1:0]   = snap_q;
`ifdef LIMBUS_MTIMER_PWM_EN
            REG_CMP:    rdata_o[CNT_W-1:0]   = cmp_q;
`endif
            default: ;
        endcase
    end

    assign irq_o = to_q & ito_q;

endmodule
`default_nettype wire

// File: rtl/limbus_mtimer.sv
`default_nettype none
// ============================================================================
// limbus_mtimer : multi-channel interval timer, 32-bit Avalon-MM slave.
// Compare/PWM outputs enabled by LIMBUS_MTIMER_PWM_EN.   Revision: 1.0
// ============================================================================
module limbus_mtimer
    import limbus_mtimer_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned PRESC_DIV  = 0,
    parameter int unsigned DEF_PERIOD = 99999
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          chipselect,
    input  logic [addr_width(NUM_CH)-1:0] address,
    input  logic                          write_n,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          irq,
    output logic [NUM_CH-1:0]             irq_vec
`ifdef LIMBUS_MTIMER_PWM_EN
    ,
    output logic [NUM_CH-1:0]             pwm_out
`endif
);

    localparam int AW = addr_width(NUM_CH);
    localparam int PW = (PRESC_DIV > 0) ? $clog2(PRESC_DIV + 1) : 1;
    localparam logic [CNT_W-1:0] C_DEF = CNT_W'(DEF_PERIOD);

    logic [PW-1:0] presc_q;
    logic          w_tick;
    logic          w_wr;
    logic [4:0]    w_ch;
    logic [31:0]   w_rdata;
    logic [31:0]   w_ch_rdata [NUM_CH];
    logic [31:0]   readdata_q;

    assign w_tick = (presc_q == PW'(PRESC_DIV));
    assign w_wr   = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) presc_q <= '0;
        else          presc_q <= w_tick ? '0 : presc_q + 1'b1;
    end

    generate
        if (AW > 3) begin : g_chidx
            assign w_ch = 5'(address[AW-1:3]);
        end else begin : g_chidx_single
            assign w_ch = 5'd0;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            limbus_mtimer_ch #(
                .CNT_W   (CNT_W),
                .DEF_VAL (C_DEF)
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .tick_i  (w_tick),
                .wr_i    (w_wr && (w_ch == 5'(i))),
                .reg_i   (address[2:0]),
                .wdata_i (writedata),
                .rdata_o (w_ch_rdata[i]),
`ifdef LIMBUS_MTIMER_PWM_EN
                .pwm_o   (pwm_out[i]),
`endif
                .irq_o   (irq_vec[i])
            );
        end
    endgenerate

    // Channel indices beyond NUM_CH match no entry and read as zero
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == 5'(i)) w_rdata = w_ch_rdata[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= w_rdata;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_limbus_mtimer.sv
`default_nettype none
// ============================================================================
// tb_limbus_mtimer : directed self-checking bench for limbus_mtimer
// Revision: 1.0
// ============================================================================
module tb_limbus_mtimer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_a, cs_b, wn;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rdata_a, rdata_b;
    logic        irq_a, irq_b;
    logic [2:0]  ivec_a;
    logic [0:0]  ivec_b;
`ifdef LIMBUS_MTIMER_PWM_EN
    logic [2:0]  pwm_a;
    logic [0:0]  pwm_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    limbus_mtimer #(.NUM_CH(3), .CNT_W(32), .PRESC_DIV(0), .DEF_PERIOD(99999)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .chipselect(cs_a), .address(addr),
        .write_n(wn), .writedata(wd), .readdata(rdata_a), .irq(irq_a), .irq_vec(ivec_a)
`ifdef LIMBUS_MTIMER_PWM_EN
        , .pwm_out(pwm_a)
`endif
    );

    limbus_mtimer #(.NUM_CH(1), .CNT_W(16), .PRESC_DIV(3), .DEF_PERIOD(99999)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .chipselect(cs_b), .address(addr[2:0]),
        .write_n(wn), .writedata(wd), .readdata(rdata_b), .irq(irq_b), .irq_vec(ivec_b)
`ifdef LIMBUS_MTIMER_PWM_EN
        , .pwm_out(pwm_b)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic wr(input bit sel_b, input logic [4:0] a, input logic [31:0] d);
        cs_a = ~sel_b; cs_b = sel_b; wn = 1'b0; addr = a; wd = d;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0; wn = 1'b1;
    endtask

    task automatic rd(input bit sel_b, input logic [4:0] a, output logic [31:0] d);
        addr = a;
        @(negedge clk);
        d = sel_b ? rdata_b : rdata_a;
    endtask

    logic [31:0] v;
    int          cyc;

    initial begin
        reset_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0; wn = 1'b1; addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        check_vec("reset_irq", {31'd0, irq_a}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values of every register on every channel
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 5; r++) begin
                rd(1'b0, 5'(ch * 8 + r), v);
                check_vec($sformatf("reset_ch%0d_r%0d", ch, r), v, (r == 2) ? 32'd99999 : 32'd0);
            end
        end
        rd(1'b1, 5'd2, v);
        check_vec("reset_b_period_trunc", v, 32'd34463);

        // ch1 continuous, PERIOD=9: 10-tick timeout
        wr(1'b0, 5'd10, 32'd9);
        wr(1'b0, 5'd8, 32'h07);
        repeat (9) @(negedge clk);
        check_vec("ch1_irq_before", {31'd0, irq_a}, 32'd0);
        @(negedge clk);
        check_vec("ch1_irq_rise", {31'd0, irq_a}, 32'd1);
        check_vec("ch1_irq_vec", {29'd0, ivec_a}, 32'd2);
        wr(1'b0, 5'd9, 32'd1);
        check_vec("ch1_irq_cleared", {31'd0, irq_a}, 32'd0);
        repeat (8) @(negedge clk);
        check_vec("ch1_irq_before2", {31'd0, irq_a}, 32'd0);
        @(negedge clk);
        check_vec("ch1_irq_rise2", {31'd0, irq_a}, 32'd1);

        // Clear coinciding with a timeout: set must win
        wr(1'b0, 5'd9, 32'd1);
        repeat (8) @(negedge clk);
        wr(1'b0, 5'd9, 32'd1);
        check_vec("clr_vs_to_irq", {31'd0, irq_a}, 32'd1);
        rd(1'b0, 5'd9, v);
        check_vec("clr_vs_to_status", v, 32'd1);
        wr(1'b0, 5'd8, 32'h08);
        wr(1'b0, 5'd9, 32'd1);
        check_vec("ch1_stopped_irq", {31'd0, irq_a}, 32'd0);

        // ch0 one-shot, PERIOD=4
        wr(1'b0, 5'd2, 32'd4);
        wr(1'b0, 5'd0, 32'h05);
        repeat (4) @(negedge clk);
        check_vec("ch0_vec_before", {29'd0, ivec_a}, 32'd0);
        @(negedge clk);
        check_vec("ch0_vec_rise", {29'd0, ivec_a}, 32'd1);
        rd(1'b0, 5'd0, v);
        check_vec("ch0_ctrl_run0", v, 32'h01);
        wr(1'b0, 5'd3, 32'd0);
        rd(1'b0, 5'd3, v);
        check_vec("ch0_snap_zero", v, 32'd0);
        wr(1'b0, 5'd1, 32'd1);
        repeat (20) @(negedge clk);
        check_vec("ch0_no_retimeout", {31'd0, irq_a}, 32'd0);

        // ch2: PERIOD write forces reload and stop; START beats STOP
        wr(1'b0, 5'd18, 32'd50);
        wr(1'b0, 5'd16, 32'h06);
        repeat (3) @(negedge clk);
        rd(1'b0, 5'd16, v);
        check_vec("ch2_ctrl_running", v, 32'h12);
        wr(1'b0, 5'd18, 32'd100);
        rd(1'b0, 5'd16, v);
        check_vec("ch2_ctrl_stopped", v, 32'h02);
        wr(1'b0, 5'd19, 32'd0);
        rd(1'b0, 5'd19, v);
        check_vec("ch2_snap_reload", v, 32'd100);
        wr(1'b0, 5'd16, 32'h0C);
        wr(1'b0, 5'd19, 32'd0);
        rd(1'b0, 5'd19, v);
        check_vec("ch2_snap_prestep", v, 32'd100);
        rd(1'b0, 5'd16, v);
        check_vec("ch2_start_wins", v, 32'h10);
        wr(1'b0, 5'd16, 32'h08);

        // Out-of-range channel and unused offsets
        wr(1'b0, 5'd26, 32'd5);
        rd(1'b0, 5'd26, v);
        check_vec("oob_ch_read", v, 32'd0);
        rd(1'b0, 5'd2, v);
        check_vec("ch0_period_kept", v, 32'd4);
        rd(1'b0, 5'd10, v);
        check_vec("ch1_period_kept", v, 32'd9);
        rd(1'b0, 5'd18, v);
        check_vec("ch2_period_kept", v, 32'd100);
        wr(1'b0, 5'd5, 32'hFFFF_FFFF);
        rd(1'b0, 5'd5, v);
        check_vec("unused_offset", v, 32'd0);
        wr(1'b0, 5'd4, 32'd3);
        rd(1'b0, 5'd4, v);
`ifdef LIMBUS_MTIMER_PWM_EN
        check_vec("compare_rw", v, 32'd3);
`else
        check_vec("compare_absent", v, 32'd0);
`endif

        // Prescaled DUT: PERIOD=7 continuous, 8 ticks x 4 clk = 32 clk
        wr(1'b1, 5'd4, 32'd3);
        wr(1'b1, 5'd2, 32'd7);
        wr(1'b1, 5'd0, 32'h07);
        cyc = 0;
        while (!irq_b && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_vec("b_first_timeout", {31'd0, irq_b}, 32'd1);
        wr(1'b1, 5'd1, 32'd1);
        cyc = 1;
        while (!irq_b && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_vec("b_interval_clk", cyc, 32'd32);
`ifdef LIMBUS_MTIMER_PWM_EN
        cyc = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (pwm_b[0]) cyc++;
        end
        check_vec("b_pwm_duty", cyc, 32'd12);
        check_vec("a_pwm_idle", {29'd0, pwm_a}, 32'd0);
`endif

        // Reset mid-count
        wr(1'b0, 5'd0, 32'h07);
        repeat (10) @(negedge clk);
        check_vec("pre_reset_irq", {31'd0, irq_a}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_vec("async_reset_irq", {28'd0, irq_a, ivec_a}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(1'b0, 5'd2, v);
        check_vec("post_reset_period", v, 32'd99999);
        rd(1'b0, 5'd0, v);
        check_vec("post_reset_ctrl", v, 32'd0);
        repeat (5) @(negedge clk);
        check_vec("post_reset_quiet", {31'd0, irq_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
